// File: rtl/ifm_rd_pkg.sv
// Shared types and default widths for the ifmap RAM reader.
// The FIFO depth here also sets the read-credit limit in the top.
package ifm_rd_pkg;

   localparam int DEF_DATA_WIDTH = 10;
   localparam int DEF_ADDR_WIDTH = 12;
   localparam int DEF_DIM_WIDTH  = 8;
   localparam int SKID_DEPTH     = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/ifm_rd_skid.sv
// Two-entry FIFO holding {last, data} words returned by the RAM.
// entry_reg[0] is always the head; push and pop may happen in the same cycle.
module ifm_rd_skid #(
   parameter int W = 11
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [1:0]   count,
   output logic         empty
);

   logic [W-1:0] entry_reg [2];
   logic [1:0]   count_reg;
   logic         pop_ok;
   logic         push_ok;

   assign pop_ok  = pop & (count_reg != 2'd0);
   assign push_ok = push & ((count_reg != 2'd2) | pop_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry_reg[0] <= '0;
         entry_reg[1] <= '0;
         count_reg    <= 2'd0;
      end else begin
         if (pop_ok) begin
            entry_reg[0] <= entry_reg[1];
            // After the shift, the incoming word lands right behind whatever remains
            if (push_ok) begin
               if (count_reg == 2'd2)
                  entry_reg[1] <= push_data;
               else
                  entry_reg[0] <= push_data;
            end
         end else if (push_ok) begin
            if (count_reg == 2'd0)
               entry_reg[0] <= push_data;
            else
               entry_reg[1] <= push_data;
         end
         count_reg <= count_reg + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

   assign head  = entry_reg[0];
   assign count = count_reg;
   assign empty = (count_reg == 2'd0);

endmodule

// File: rtl/ifm_ram_reader.sv
// Walks a rows x cols window of the ifmap RAM and streams it over valid/ready.
// A word still in flight from the RAM is presented directly when the FIFO is empty.
module ifm_ram_reader
   import ifm_rd_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DIM_WIDTH  = DEF_DIM_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
   input  logic [DIM_WIDTH-1:0]  cfg_rows,
   input  logic [DIM_WIDTH-1:0]  cfg_cols,
   input  logic [ADDR_WIDTH-1:0] cfg_stride,
   output logic                  busy,
   output logic                  done,
   output logic                  ram_read_req,
   output logic [ADDR_WIDTH-1:0] ram_read_addr,
   input  logic [DATA_WIDTH-1:0] ram_read_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last
);

   state_t                state_reg, state_next;
   logic [DIM_WIDTH-1:0]  rows_reg, cols_reg;
   logic [DIM_WIDTH-1:0]  row_cnt_reg, col_cnt_reg;
   logic [ADDR_WIDTH-1:0] stride_reg, addr_reg, row_start_reg;
   logic                  inflight_reg, inflight_last_reg;

   logic [DATA_WIDTH:0]   skid_head, ram_word, head_word;
   logic [1:0]            skid_count;
   logic                  skid_empty, skid_push, skid_pop;
   logic                  credit_ok, last_col, last_row, accept_start;

   assign ram_word  = {inflight_last_reg, ram_read_data};
   assign head_word = skid_empty ? ram_word : skid_head;

   assign m_valid   = ~skid_empty | inflight_reg;
   assign m_data    = m_valid ? head_word[DATA_WIDTH-1:0] : '0;
   assign m_last    = m_valid & head_word[DATA_WIDTH];

   // An in-flight word bypasses the FIFO only when it is empty and the sink takes it now
   assign skid_pop  = m_valid & m_ready & ~skid_empty;
   assign skid_push = inflight_reg & ~(skid_empty & m_ready);

   ifm_rd_skid #(.W(DATA_WIDTH + 1)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (skid_push),
      .push_data (ram_word),
      .pop       (skid_pop),
      .head      (skid_head),
      .count     (skid_count),
      .empty     (skid_empty)
   );

   assign credit_ok    = ({1'b0, skid_count} + {2'b00, inflight_reg}) < 3'(SKID_DEPTH);
   assign last_col     = (col_cnt_reg == cols_reg - DIM_WIDTH'(1));
   assign last_row     = (row_cnt_reg == rows_reg - DIM_WIDTH'(1));
   assign accept_start = (state_reg == IDLE) & start;
   assign busy         = (state_reg != IDLE);
   assign ram_read_addr = ram_read_req ? addr_reg : '0;

   always_comb begin
      state_next   = state_reg;
      ram_read_req = 1'b0;
      done         = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start)
               state_next = ((cfg_rows == '0) || (cfg_cols == '0)) ? DRAIN : RUN;
         end
         RUN: begin
            ram_read_req = credit_ok;
            if (credit_ok && last_col && last_row)
               state_next = DRAIN;
         end
         DRAIN: begin
            if (skid_empty && !inflight_reg) begin
               done       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rows_reg          <= '0;
         cols_reg          <= '0;
         stride_reg        <= '0;
         row_cnt_reg       <= '0;
         col_cnt_reg       <= '0;
         addr_reg          <= '0;
         row_start_reg     <= '0;
         inflight_reg      <= 1'b0;
         inflight_last_reg <= 1'b0;
      end else begin
         inflight_reg      <= ram_read_req;
         inflight_last_reg <= ram_read_req & last_col & last_row;
         if (accept_start) begin
            rows_reg      <= cfg_rows;
            cols_reg      <= cfg_cols;
            stride_reg    <= cfg_stride;
            row_cnt_reg   <= '0;
            col_cnt_reg   <= '0;
            addr_reg      <= cfg_base_addr;
            row_start_reg <= cfg_base_addr;
         end else if (ram_read_req) begin
            // Incremental address walk; all sums wrap at the address width
            if (last_col) begin
               col_cnt_reg   <= '0;
               row_cnt_reg   <= row_cnt_reg + DIM_WIDTH'(1);
               row_start_reg <= row_start_reg + stride_reg;
               addr_reg      <= row_start_reg + stride_reg;
            end else begin
               col_cnt_reg <= col_cnt_reg + DIM_WIDTH'(1);
               addr_reg    <= addr_reg + ADDR_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_ifm_ram_reader.sv
// Scoreboard bench for ifm_ram_reader: expected addresses and words are queued at start
// and checked as the DUT issues reads and completes stream handshakes.
module tb_ifm_ram_reader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [11:0] cfg_base_addr;
   logic [7:0]  cfg_rows;
   logic [7:0]  cfg_cols;
   logic [11:0] cfg_stride;
   logic        busy;
   logic        done;
   logic        ram_read_req;
   logic [11:0] ram_read_addr;
   logic [9:0]  ram_read_data;
   logic        m_valid;
   logic        m_ready;
   logic [9:0]  m_data;
   logic        m_last;

   logic [9:0]  mem [4096];

   int n_vec = 0;
   int n_err = 0;

   ifm_ram_reader #(.DATA_WIDTH(10), .ADDR_WIDTH(12), .DIM_WIDTH(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .cfg_base_addr (cfg_base_addr),
      .cfg_rows      (cfg_rows),
      .cfg_cols      (cfg_cols),
      .cfg_stride    (cfg_stride),
      .busy          (busy),
      .done          (done),
      .ram_read_req  (ram_read_req),
      .ram_read_addr (ram_read_addr),
      .ram_read_data (ram_read_data),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_data        (m_data),
      .m_last        (m_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: one-cycle registered read
   always @(posedge clk) begin
      if (ram_read_req)
         ram_read_data <= mem[ram_read_addr];
   end

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_vec++;
      if ({busy, done, ram_read_req, ram_read_addr, m_valid, m_data, m_last} !== 27'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got busy=%b done=%b req=%b addr=%0d valid=%b data=%0d last=%b, want all 0",
                  busy, done, ram_read_req, ram_read_addr, m_valid, m_data, m_last);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // mode: 0 always ready, 1 ready toggles 1010.., 2 stall 20 cycles, 3 random ready
   // gcyc: cycle at which a stray start (different cfg) is pulsed; 0 = none
   task automatic run_window(input logic [11:0] base, input logic [7:0] rows,
                             input logic [7:0] cols, input logic [11:0] stride,
                             input int mode, input int gcyc, input string name);
      logic [11:0] exp_addr_q [$];
      logic [10:0] exp_word_q [$];
      logic [11:0] a;
      logic [11:0] exp_a;
      logic [10:0] exp_w;
      logic [9:0]  prev_data;
      logic        prev_stall;
      int n, cyc, last_hs, pending, n_words;
      bit finished;

      n = int'(rows) * int'(cols);
      for (int r = 0; r < int'(rows); r++) begin
         for (int c = 0; c < int'(cols); c++) begin
            a = base + 12'(r) * stride + 12'(c);
            exp_addr_q.push_back(a);
            exp_word_q.push_back({(r == int'(rows) - 1) && (c == int'(cols) - 1), mem[a]});
         end
      end

      @(negedge clk);
      cfg_base_addr = base;
      cfg_rows      = rows;
      cfg_cols      = cols;
      cfg_stride    = stride;
      start         = 1'b1;
      @(negedge clk);
      start = 1'b0;

      cyc = 1; last_hs = 0; pending = 0; n_words = 0;
      prev_stall = 1'b0; prev_data = '0; finished = 1'b0;
      while (!finished && cyc <= 2000) begin
         case (mode)
            0: m_ready = 1'b1;
            1: m_ready = (cyc % 2 == 1);
            2: m_ready = !(cyc >= 4 && cyc <= 23);
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
         if (cyc == gcyc) begin
            start         = 1'b1;
            cfg_base_addr = 12'h555;
            cfg_rows      = 8'd1;
            cfg_cols      = 8'd1;
         end
         #1;
         n_vec++;
         if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s busy_high: cycle %0d busy=%b, want 1", name, cyc, busy);
         end
         if (ram_read_req) begin
            n_vec++;
            if (pending > 1) begin
               n_err++;
               $display("FAIL %s outstanding: cycle %0d has %0d unconsumed reads plus a new one, want at most 2 total",
                        name, cyc, pending);
            end
            n_vec++;
            if (exp_addr_q.size() == 0) begin
               n_err++;
               $display("FAIL %s extra_read: cycle %0d addr=%0d, want no more reads", name, cyc, ram_read_addr);
            end else begin
               exp_a = exp_addr_q.pop_front();
               if (ram_read_addr !== exp_a) begin
                  n_err++;
                  $display("FAIL %s read_addr: cycle %0d addr=%0d, want %0d", name, cyc, ram_read_addr, exp_a);
               end
            end
         end
         if (mode == 0 && cyc <= n) begin
            n_vec++;
            if (ram_read_req !== 1'b1) begin
               n_err++;
               $display("FAIL %s req_rate: cycle %0d req=%b, want 1", name, cyc, ram_read_req);
            end
         end
         if (mode == 0 && cyc >= 2 && cyc <= n + 1) begin
            n_vec++;
            if (m_valid !== 1'b1) begin
               n_err++;
               $display("FAIL %s valid_rate: cycle %0d m_valid=%b, want 1", name, cyc, m_valid);
            end
         end
         if (prev_stall) begin
            n_vec++;
            if (m_valid !== 1'b1 || m_data !== prev_data) begin
               n_err++;
               $display("FAIL %s hold_stable: cycle %0d valid=%b data=%0d, want valid=1 data=%0d",
                        name, cyc, m_valid, m_data, prev_data);
            end
         end
         if (!m_valid) begin
            n_vec++;
            if (m_last !== 1'b0) begin
               n_err++;
               $display("FAIL %s last_gated: cycle %0d m_last=%b without m_valid, want 0", name, cyc, m_last);
            end
         end
         if (m_valid && m_ready) begin
            n_vec++;
            if (exp_word_q.size() == 0) begin
               n_err++;
               $display("FAIL %s extra_word: cycle %0d data=%0d, want no more words", name, cyc, m_data);
            end else begin
               exp_w = exp_word_q.pop_front();
               if ({m_last, m_data} !== exp_w) begin
                  n_err++;
                  $display("FAIL %s word: cycle %0d last=%b data=%0d, want last=%b data=%0d",
                           name, cyc, m_last, m_data, exp_w[10], exp_w[9:0]);
               end
            end
            last_hs = cyc;
            n_words++;
         end
         if (mode == 2 && cyc == 23) begin
            n_vec++;
            if (ram_read_req !== 1'b0 || pending != 2) begin
               n_err++;
               $display("FAIL %s stall_credit: req=%b outstanding=%0d, want req=0 outstanding=2",
                        name, ram_read_req, pending);
            end
         end
         if (done) begin
            n_vec++;
            if (cyc != last_hs + 1 || exp_word_q.size() != 0 || exp_addr_q.size() != 0) begin
               n_err++;
               $display("FAIL %s done_timing: done at cycle %0d with %0d words left, want cycle %0d with 0 left",
                        name, cyc, exp_word_q.size(), last_hs + 1);
            end
            finished = 1'b1;
         end
         pending = pending + int'(ram_read_req) - int'(m_valid && m_ready);
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         @(negedge clk);
         start = 1'b0;
         cyc++;
      end
      if (!finished) begin
         n_vec++;
         n_err++;
         $display("FAIL %s timeout: no done within 2000 cycles, want done", name);
      end
      m_ready = 1'b1;
      #1;
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || ram_read_req !== 1'b0) begin
         n_err++;
         $display("FAIL %s idle_after: busy=%b done=%b req=%b, want 0 0 0", name, busy, done, ram_read_req);
      end
      $display("window %s base=%0d rows=%0d cols=%0d stride=%0d mode=%0d: %0d words in %0d cycles",
               name, base, rows, cols, stride, mode, n_words, cyc - 1);
   endtask

   task automatic test_basic();
      run_window(12'd0, 8'd2, 8'd3, 12'd8, 0, 0, "basic");
   endtask

   task automatic test_backpressure_toggle();
      run_window(12'd0, 8'd2, 8'd3, 12'd8, 1, 0, "toggle");
   endtask

   task automatic test_stall();
      run_window(12'd100, 8'd3, 8'd5, 12'd40, 2, 0, "stall");
   endtask

   task automatic test_wrap();
      run_window(12'd4094, 8'd1, 8'd4, 12'd8, 0, 0, "wrap");
      run_window(12'd4000, 8'd3, 8'd2, 12'd60, 1, 0, "row_wrap");
   endtask

   task automatic test_zero_dims();
      run_window(12'd0, 8'd2, 8'd0, 12'd8, 0, 1, "zero_cols");
      run_window(12'd7, 8'd0, 8'd4, 12'd8, 0, 0, "zero_rows");
   endtask

   task automatic test_start_ignored();
      run_window(12'd20, 8'd2, 8'd4, 12'd16, 0, 3, "start_busy");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++)
         run_window(12'($urandom), 8'($urandom_range(1, 6)), 8'($urandom_range(1, 6)),
                    12'($urandom), 3, 0, "random");
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      cfg_base_addr = 12'd200;
      cfg_rows      = 8'd3;
      cfg_cols      = 8'd5;
      cfg_stride    = 12'd32;
      start         = 1'b1;
      m_ready       = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({busy, done, ram_read_req, ram_read_addr, m_valid, m_data, m_last} !== 27'd0) begin
         n_err++;
         $display("FAIL async_reset: got busy=%b done=%b req=%b addr=%0d valid=%b data=%0d last=%b, want all 0",
                  busy, done, ram_read_req, ram_read_addr, m_valid, m_data, m_last);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_window(12'd300, 8'd2, 8'd3, 12'd10, 0, 0, "after_reset");
   endtask

   initial begin
      for (int i = 0; i < 4096; i++)
         mem[i] = 10'($urandom);
      rst_n         = 1'b0;
      start         = 1'b0;
      cfg_base_addr = '0;
      cfg_rows      = '0;
      cfg_cols      = '0;
      cfg_stride    = '0;
      m_ready       = 1'b0;

      test_reset();
      test_basic();
      test_backpressure_toggle();
      test_stall();
      test_wrap();
      test_zero_dims();
      test_start_ignored();
      test_back_to_back();
      test_async_reset();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
